// File: rtl/fp_divider_seq.sv
// -----------------------------------------------------------------------------
// fp_divider_seq
// Multi-cycle IEEE-754 single-precision divider (out = a / b).
// Restoring mantissa division producing one quotient bit per clock.
// Results are truncated toward zero. Denormal operands and results flush to zero.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, sampled only while busy=0
//   a, b   dividend / divisor {sign, exp, man}
//   busy   high from the accept edge until the done cycle
//   done   one-cycle pulse; out/dz/nv valid then, out held until next accept
//   out    quotient
//   dz     divide-by-zero flag
//   nv     invalid-operation flag
// -----------------------------------------------------------------------------
module fp_divider_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int BIAS  = 127
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic                   busy,
   output logic                   done,
   output logic [EXP_W+MAN_W:0]   out,
   output logic                   dz,
   output logic                   nv
);

   localparam int W     = EXP_W + MAN_W + 1;
   localparam int SW    = EXP_W + 2;              // signed working exponent width
   localparam int CNT_W = $clog2(MAN_W + 2);
   localparam logic [EXP_W-1:0]      EXP_MAX   = '1;
   localparam logic signed [SW-1:0]  EXP_MAX_S = SW'((1 << EXP_W) - 1);
   localparam logic [W-1:0]          QNAN      = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_NORM} state_t;

   state_t                  r_state, w_state_next;
   logic [W-1:0]            r_a, r_b;
   logic [MAN_W:0]          r_mb;
   logic [MAN_W+2:0]        r_rem;
   logic [MAN_W+1:0]        r_q;
   logic signed [SW-1:0]    r_exp;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_busy, r_done, r_dz, r_nv;
   logic [W-1:0]            r_out;

   // Operand classification (operands are held in r_a/r_b for the whole op)
   logic [EXP_W-1:0] w_ea, w_eb;
   logic [MAN_W-1:0] w_man_a, w_man_b;
   logic             w_sign;
   logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
   logic [W-1:0]     w_inf, w_zero;

   assign w_ea     = r_a[W-2:MAN_W];
   assign w_eb     = r_b[W-2:MAN_W];
   assign w_man_a  = r_a[MAN_W-1:0];
   assign w_man_b  = r_b[MAN_W-1:0];
   assign w_sign   = r_a[W-1] ^ r_b[W-1];
   assign w_a_zero = (w_ea == '0);
   assign w_b_zero = (w_eb == '0);
   assign w_a_inf  = (w_ea == EXP_MAX) && (w_man_a == '0);
   assign w_b_inf  = (w_eb == EXP_MAX) && (w_man_b == '0);
   assign w_a_nan  = (w_ea == EXP_MAX) && (w_man_a != '0);
   assign w_b_nan  = (w_eb == EXP_MAX) && (w_man_b != '0);
   assign w_inf    = {w_sign, EXP_MAX, {MAN_W{1'b0}}};
   assign w_zero   = {w_sign, {(W-1){1'b0}}};

   // Special-case resolution; order matters (NaN cases dominate, inf/0 is not dz)
   logic         w_special, w_special_dz, w_special_nv;
   logic [W-1:0] w_special_out;

   always_comb begin
      w_special     = 1'b1;
      w_special_dz  = 1'b0;
      w_special_nv  = 1'b0;
      w_special_out = w_zero;
      if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
         w_special_out = QNAN;
         w_special_nv  = 1'b1;
      end else if (w_a_inf) begin
         w_special_out = w_inf;
      end else if (w_b_zero) begin
         w_special_out = w_inf;
         w_special_dz  = 1'b1;
      end else if (w_a_zero || w_b_inf) begin
         w_special_out = w_zero;
      end else begin
         w_special     = 1'b0;
      end
   end

   logic signed [SW-1:0] w_exp_calc;
   assign w_exp_calc = SW'({2'b00, w_ea} - {2'b00, w_eb} + SW'(BIAS));

   // One restoring-division step
   logic             w_ge;
   logic [MAN_W+2:0] w_rem_diff;
   assign w_ge       = (r_rem >= {2'b00, r_mb});
   assign w_rem_diff = w_ge ? (r_rem - {2'b00, r_mb}) : r_rem;

   // Normalisation: quotient of two [1,2) mantissas lies in (0.5, 2)
   logic signed [SW-1:0] w_norm_exp;
   logic [MAN_W-1:0]     w_norm_man;
   logic [W-1:0]         w_norm_out;

   assign w_norm_exp = r_q[MAN_W+1] ? r_exp : (r_exp - SW'(1));
   assign w_norm_man = r_q[MAN_W+1] ? r_q[MAN_W:1] : r_q[MAN_W-1:0];

   always_comb begin
      w_norm_out = {w_sign, w_norm_exp[EXP_W-1:0], w_norm_man};
      if (w_norm_exp >= EXP_MAX_S) begin
         w_norm_out = w_inf;
      end else if (w_norm_exp <= SW'(0)) begin
         w_norm_out = w_zero;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_state_next = S_UNPACK;
         S_UNPACK: w_state_next = w_special ? S_IDLE : S_DIVIDE;
         S_DIVIDE: if (r_cnt == CNT_W'(MAN_W + 1)) w_state_next = S_NORM;
         S_NORM:   w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_mb   <= '0;
         r_rem  <= '0;
         r_q    <= '0;
         r_exp  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_dz   <= 1'b0;
         r_nv   <= 1'b0;
         r_out  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a    <= a;
                  r_b    <= b;
                  r_busy <= 1'b1;
                  r_dz   <= 1'b0;
                  r_nv   <= 1'b0;
               end
            end
            S_UNPACK: begin
               if (w_special) begin
                  r_out  <= w_special_out;
                  r_dz   <= w_special_dz;
                  r_nv   <= w_special_nv;
                  r_done <= 1'b1;
                  r_busy <= 1'b0;
               end else begin
                  r_rem  <= {2'b01, w_man_a};
                  r_mb   <= {1'b1, w_man_b};
                  r_q    <= '0;
                  r_exp  <= w_exp_calc;
                  r_cnt  <= '0;
               end
            end
            S_DIVIDE: begin
               r_q   <= {r_q[MAN_W:0], w_ge};
               r_rem <= {w_rem_diff[MAN_W+1:0], 1'b0};
               r_cnt <= r_cnt + CNT_W'(1);
            end
            S_NORM: begin
               r_out  <= w_norm_out;
               r_done <= 1'b1;
               r_busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign out  = r_out;
   assign dz   = r_dz;
   assign nv   = r_nv;

endmodule

// File: tb/tb_fp_divider_seq.sv
module tb_fp_divider_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy, done, dz, nv;
   logic [31:0] out;

   int n_cmp = 0;
   int n_err = 0;

   fp_divider_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .out   (out),
      .dz    (dz),
      .nv    (nv)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs == exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: truncated quotient of the real values, from the field rules
   function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] o, output logic o_dz,
                                 output logic o_nv, output int lat);
      int ex, ey, e;
      int unsigned mx, my;
      logic s, x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
      longint unsigned fa, fb, m;
      ex = int'(x[30:23]);  ey = int'(y[30:23]);
      mx = int'(x[22:0]);   my = int'(y[22:0]);
      s  = x[31] ^ y[31];
      x_zero = (ex == 0);   y_zero = (ey == 0);
      x_inf  = (ex == 255) && (mx == 0);
      y_inf  = (ey == 255) && (my == 0);
      x_nan  = (ex == 255) && (mx != 0);
      y_nan  = (ey == 255) && (my != 0);
      o_dz = 1'b0; o_nv = 1'b0; lat = 1;
      if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
         o = 32'h7FC00000; o_nv = 1'b1;
      end else if (x_inf) begin
         o = {s, 31'h7F800000};
      end else if (y_zero) begin
         o = {s, 31'h7F800000}; o_dz = 1'b1;
      end else if (x_zero || y_inf) begin
         o = {s, 31'h0};
      end else begin
         lat = 27;
         fa = 64'(mx) + 64'h800000;
         fb = 64'(my) + 64'h800000;
         e  = ex - ey + 127;
         if (fa >= fb) m = (fa << 23) / fb;
         else begin
            m = (fa << 24) / fb;
            e = e - 1;
         end
         if (e >= 255)     o = {s, 31'h7F800000};
         else if (e <= 0)  o = {s, 31'h0};
         else              o = {s, 8'(e), 23'(m)};
      end
   endfunction

   // Present operands, cross the accept edge, then scramble the inputs
   task automatic issue(input logic [31:0] x, input logic [31:0] y);
      start = 1'b1; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0; a = $urandom; b = $urandom;
      chkb("accept_busy", busy, 1'b1);
      chkb("accept_done", done, 1'b0);
   endtask

   // Bounded wait for done; cyc counts edges after accept, bcnt busy samples
   task automatic wait_done(output int cyc, output int bcnt);
      cyc = 0; bcnt = 1;
      while (done !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (busy === 1'b1) bcnt++;
      end
      chkb("done_seen", done, 1'b1);
   endtask

   task automatic check_res(input logic [31:0] x, input logic [31:0] y,
                            input int cyc, input int bcnt, input bit chk_lat);
      logic [31:0] eo; logic edz, env; int elat;
      model(x, y, eo, edz, env, elat);
      chk("out", out, eo);
      chkb("dz", dz, edz);
      chkb("nv", nv, env);
      chkb("busy_low_at_done", busy, 1'b0);
      if (chk_lat) begin
         chki("latency", cyc, elat);
         chki("busy_cycles", bcnt, elat);
      end
      $display("op %08h / %08h -> %08h dz=%b nv=%b lat=%0d", x, y, out, dz, nv, cyc);
   endtask

   task automatic run(input logic [31:0] x, input logic [31:0] y);
      int cyc, bcnt;
      logic [31:0] held;
      issue(x, y);
      wait_done(cyc, bcnt);
      check_res(x, y, cyc, bcnt, 1'b1);
      held = out;
      @(posedge clk); #1;
      chkb("done_pulse_clears", done, 1'b0);
      chk("out_held", out, held);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, bcnt, r;
      logic [31:0] x, y;

      // Reset state
      #1;
      chkb("rst_busy", busy, 1'b0);
      chkb("rst_done", done, 1'b0);
      chk("rst_out", out, 32'h0);
      chkb("rst_dz", dz, 1'b0);
      chkb("rst_nv", nv, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases with literal expected values
      run(32'h40C00000, 32'h40000000); chk("six_div_two", out, 32'h40400000);
      run(32'h3F800000, 32'h40400000); chk("one_third_trunc", out, 32'h3EAAAAAA);
      run(32'hC1400000, 32'h3F000000); chk("neg12_div_half", out, 32'hC1C00000);
      run(32'h40000000, 32'h80000000); chk("div_by_neg_zero", out, 32'hFF800000);
      chkb("div_by_zero_dz", dz, 1'b1);
      run(32'h00000000, 32'h00000000); chk("zero_div_zero", out, 32'h7FC00000);
      chkb("zero_div_zero_nv", nv, 1'b1);
      run(32'h7F000000, 32'h3E800000); chk("overflow", out, 32'h7F800000);
      run(32'h00800000, 32'h4B000000); chk("underflow", out, 32'h00000000);
      run(32'h7F800000, 32'h7F800000);
      run(32'h7FC00001, 32'h3F800000);
      run(32'hFF800000, 32'h40000000);
      run(32'h3F800000, 32'hFF800000);
      run(32'h3FFFFFFF, 32'h3F800001);

      // Restart ignored while busy, then back-to-back issue in the done cycle
      issue(32'h40C00000, 32'h40000000);
      repeat (9) begin @(posedge clk); #1; end
      start = 1'b1; a = 32'h3F800000; b = 32'h40400000;
      @(posedge clk); #1;
      start = 1'b0;
      chkb("restart_still_busy", busy, 1'b1);
      wait_done(cyc, bcnt);
      chk("restart_ignored_out", out, 32'h40400000);
      chki("restart_remaining_edges", cyc, 17);
      issue(32'hC1400000, 32'h3F000000);
      wait_done(cyc, bcnt);
      check_res(32'hC1400000, 32'h3F000000, cyc, bcnt, 1'b1);
      chk("back_to_back_out", out, 32'hC1C00000);
      @(posedge clk); #1;

      // Reset in the middle of a divide
      issue(32'h40C00000, 32'h40000000);
      repeat (11) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      chkb("midrst_busy", busy, 1'b0);
      chkb("midrst_done", done, 1'b0);
      chk("midrst_out", out, 32'h0);
      chkb("midrst_dz", dz, 1'b0);
      chkb("midrst_nv", nv, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         chkb("no_done_after_abort", done, 1'b0);
      end
      run(32'h40C00000, 32'h40000000); chk("after_reset_six_div_two", out, 32'h40400000);

      // Randomized operands against the reference model
      for (int i = 0; i < 60; i++) begin
         x = $urandom; y = $urandom;
         r = int'($urandom_range(0, 9));
         case (r)
            0: x[30:23] = 8'h00;
            1: y[30:23] = 8'h00;
            2: x[30:23] = 8'hFF;
            3: begin y[30:23] = 8'hFF; y[22:0] = '0; end
            4: y[22:0] = x[22:0];
            5: begin x[30:23] = 8'($urandom_range(100, 154)); y[30:23] = 8'($urandom_range(100, 154)); end
            default: ;
         endcase
         run(x, y);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
